// File: rtl/truth_table_reader.sv
// Exhaustive evaluator for a 5-input, 1-output circuit: steps {a,b,c,d,e} through
// all 32 vectors, samples y after SETTLE cycles each and scores it against exp_tt.
module truth_table_reader #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] exp_tt,
    input  logic        y,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        e,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [31:0] tt,
    output logic [5:0]  mismatch_cnt,
    output logic [4:0]  first_bad
);

    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
        $error("truth_table_reader: SETTLE must be 1..15");
    end

    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] exp_q, exp_d;
    logic [31:0] tt_q, tt_d;
    logic [5:0]  mcnt_q, mcnt_d;
    logic [4:0]  fbad_q, fbad_d;
    logic [4:0]  vec;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        tt_d    = tt_q;
        mcnt_d  = mcnt_q;
        fbad_d  = fbad_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    idx_d   = '0;
                    cnt_d   = '0;
                    exp_d   = exp_tt;
                    tt_d    = '0;
                    mcnt_d  = '0;
                    fbad_d  = '0;
                end
            end
            S_RUN: begin
                if (cnt_q == CNT_LAST) begin
                    tt_d[idx_q] = y;
                    if (y != exp_q[idx_q]) begin
                        mcnt_d = mcnt_q + 6'd1;
                        // a zero count means this is the run's first mismatch
                        if (mcnt_q == '0) fbad_d = idx_q;
                    end
                    if (idx_q == 5'd31) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 5'd1;
                        cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
            tt_q    <= '0;
            mcnt_q  <= '0;
            fbad_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            tt_q    <= tt_d;
            mcnt_q  <= mcnt_d;
            fbad_q  <= fbad_d;
        end
    end

    assign vec             = (state_q == S_RUN) ? idx_q : 5'd0;
    assign {a, b, c, d, e} = vec;
    assign busy            = (state_q == S_RUN);
    assign done            = (state_q == S_DONE);
    assign pass            = done && (mcnt_q == '0);
    assign tt              = tt_q;
    assign mismatch_cnt    = mcnt_q;
    assign first_bad       = fbad_q;

endmodule

// File: tb/tb_truth_table_reader.sv
// Randomized scoreboard bench: two readers (SETTLE=1 and SETTLE=3) driving modelled
// 5-input circuits; a monitor scores every completed run against a reference model.
module tb_truth_table_reader;

    logic        clk = 0;
    logic        rst_n = 0;
    logic [1:0]  start = '0;
    logic [1:0]  y, a, b, c, d, e, busy, done, pass;
    logic [31:0] exp_tt [2];
    logic [31:0] tt [2];
    logic [5:0]  mcnt [2];
    logic [4:0]  fbad [2];
    int          ymode [2];
    logic [31:0] rtab [2];
    int          cyc = 0;
    int          ntot = 0, npass = 0;

    typedef struct {
        logic [31:0] tt;
        logic [5:0]  mc;
        logic [4:0]  fb;
        logic        ps;
        int          dcyc;
    } exp_t;
    exp_t q0[$], q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    truth_table_reader #(.SETTLE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .exp_tt(exp_tt[0]), .y(y[0]),
        .a(a[0]), .b(b[0]), .c(c[0]), .d(d[0]), .e(e[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .tt(tt[0]),
        .mismatch_cnt(mcnt[0]), .first_bad(fbad[0]));

    truth_table_reader #(.SETTLE(3)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .exp_tt(exp_tt[1]), .y(y[1]),
        .a(a[1]), .b(b[1]), .c(c[1]), .d(d[1]), .e(e[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .tt(tt[1]),
        .mismatch_cnt(mcnt[1]), .first_bad(fbad[1]));

    // Circuit under evaluation: 0:y=e 1:y=a 2:y=0 3:y=d 4:y=b 5:lookup table
    function automatic logic yfun(input int mode, input logic [4:0] v, input logic [31:0] rt);
        case (mode)
            0: return v[0];
            1: return v[4];
            2: return 1'b0;
            3: return v[1];
            4: return v[3];
            default: return rt[v];
        endcase
    endfunction

    assign y[0] = yfun(ymode[0], {a[0], b[0], c[0], d[0], e[0]}, rtab[0]);
    assign y[1] = yfun(ymode[1], {a[1], b[1], c[1], d[1], e[1]}, rtab[1]);

    function automatic exp_t model(input int mode, input logic [31:0] ex,
                                   input logic [31:0] rt, input int dcyc);
        exp_t r;
        bit   seen = 0;
        r.tt = '0; r.mc = '0; r.fb = '0; r.dcyc = dcyc;
        for (int i = 0; i < 32; i++) begin
            logic yv;
            yv = yfun(mode, 5'(i), rt);
            r.tt[i] = yv;
            if (yv != ex[i]) begin
                r.mc = r.mc + 6'd1;
                if (!seen) r.fb = 5'(i);
                seen = 1;
            end
        end
        r.ps = (r.mc == 0);
        return r;
    endfunction

    task automatic chk(input logic ok, input string nm, input logic [31:0] act, input logic [31:0] req);
        ntot++;
        if (ok) npass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    endtask

    // Monitor: vector sequencing, idle outputs, and scoreboard pop on done rising
    logic [1:0] bprev = '0, dprev = '0;
    logic [4:0] vprev [2];
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [4:0] v;
            exp_t r;
            bit   have;
            v = {a[k], b[k], c[k], d[k], e[k]};
            if (busy[k]) begin
                if (!bprev[k]) chk(v == 5'd0, "vec_first", 32'(v), 0);
                else chk(v == vprev[k] || {1'b0, v} == {1'b0, vprev[k]} + 6'd1,
                         "vec_step", 32'(v), 32'(vprev[k]));
            end else begin
                chk(v == 5'd0, "idle_vec", 32'(v), 0);
                if (!done[k]) chk(pass[k] == 1'b0, "pass_ndone", 32'(pass[k]), 0);
            end
            if (done[k] && !dprev[k]) begin
                have = 0;
                if (k == 0 && q0.size() > 0) begin r = q0.pop_front(); have = 1; end
                if (k == 1 && q1.size() > 0) begin r = q1.pop_front(); have = 1; end
                chk(have, "sb_empty", 0, 1);
                if (have) begin
                    chk(tt[k] == r.tt, "tt", tt[k], r.tt);
                    chk(mcnt[k] == r.mc, "mismatch_cnt", 32'(mcnt[k]), 32'(r.mc));
                    chk(fbad[k] == r.fb, "first_bad", 32'(fbad[k]), 32'(r.fb));
                    chk(pass[k] == r.ps, "pass", 32'(pass[k]), 32'(r.ps));
                    chk(cyc == r.dcyc, "done_cycle", cyc, r.dcyc);
                    chk(busy[k] == 1'b0, "busy_at_done", 32'(busy[k]), 0);
                end
            end
            bprev[k] = busy[k];
            dprev[k] = done[k];
            vprev[k] = v;
        end
    end

    task automatic push(input int k, input exp_t r);
        if (k == 0) q0.push_back(r); else q1.push_back(r);
    endtask

    task automatic wait_done(input int k, input int lim);
        int n = 0;
        while (!done[k] && n < lim) begin @(negedge clk); n++; end
        if (!done[k]) chk(0, "timeout", n, lim);
    endtask

    // Caller is at a negedge; start is seen by the following posedge
    task automatic run(input int k, input int mode, input logic [31:0] ex, input logic [31:0] rt);
        int s;
        s = (k == 0) ? 1 : 3;
        ymode[k] = mode; rtab[k] = rt; exp_tt[k] = ex;
        push(k, model(mode, ex, rt, cyc + 1 + 32 * s));
        start[k] = 1;
        @(negedge clk);
        start[k] = 0;
        wait_done(k, 32 * s + 10);
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string nm);
        for (int k = 0; k < 2; k++) begin
            logic [31:0] agg;
            agg = {15'd0, a[k], b[k], c[k], d[k], e[k], busy[k], done[k], pass[k],
                   mcnt[k], fbad[k]} | tt[k];
            chk(agg == 0, nm, agg, 0);
        end
    endtask

    initial begin
        int   c0;
        exp_t r;
        logic [31:0] ex, rt;
        int   mode, k;
        ymode[0] = 2; ymode[1] = 2; rtab[0] = '0; rtab[1] = '0;
        exp_tt[0] = '0; exp_tt[1] = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset_state");
        rst_n = 1;
        @(negedge clk);

        run(0, 0, 32'hAAAAAAAA, 0);   // y=e, all match
        run(1, 1, 32'hFFEF0020, 0);   // y=a, SETTLE=3, bits 5 and 20 wrong
        run(0, 2, 32'hFFFFFFFF, 0);   // every vector mismatches

        // start held through the run plus 5 cycles: back-to-back runs
        ymode[0] = 3; exp_tt[0] = 32'hCCCCCCCC;
        c0 = cyc;
        r = model(3, 32'hCCCCCCCC, 0, c0 + 33); push(0, r);
        r.dcyc = c0 + 66; push(0, r);
        start[0] = 1;
        for (int j = 1; j <= 37; j++) begin
            @(negedge clk);
            if (j == 34) begin
                chk({a[0], b[0], c[0], d[0], e[0]} == 5'd0, "restart_vec",
                    32'({a[0], b[0], c[0], d[0], e[0]}), 0);
                chk(tt[0] == 0, "restart_tt", tt[0], 0);
                chk(busy[0] && !done[0], "restart_busy", {busy[0], done[0]}, 2);
            end
        end
        start[0] = 0;
        wait_done(0, 40);
        @(negedge clk);

        // reset at vector 17, then a fresh run starting on the release edge
        ymode[0] = 4; exp_tt[0] = 32'h12345678;
        push(0, model(4, 32'h12345678, 0, cyc + 1 + 32));
        start[0] = 1;
        @(negedge clk);
        start[0] = 0;
        for (int n = 0; n < 40 && {a[0], b[0], c[0], d[0], e[0]} != 5'd17; n++) @(negedge clk);
        chk({a[0], b[0], c[0], d[0], e[0]} == 5'd17, "reach_vec17",
            32'({a[0], b[0], c[0], d[0], e[0]}), 17);
        rst_n = 0;
        #1;
        chk_all_zero("async_reset");
        q0.delete();
        @(negedge clk);
        rst_n = 1;
        run(0, 4, 32'hFF00FF00, 0);

        // exp_tt change and start pulse mid-run must be ignored
        rt = $urandom;
        ex = $urandom;
        ymode[0] = 5; rtab[0] = rt; exp_tt[0] = ex;
        push(0, model(5, ex, rt, cyc + 1 + 32));
        start[0] = 1;
        @(negedge clk);
        start[0] = 0;
        repeat (9) @(negedge clk);
        exp_tt[0] = '0; start[0] = 1;
        @(negedge clk);
        start[0] = 0;
        wait_done(0, 42);
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            k    = i % 2;
            mode = $urandom_range(0, 5);
            rt   = $urandom;
            ex   = model(mode, 0, rt, 0).tt;
            if ($urandom_range(0, 1) == 1) ex = $urandom;
            else repeat ($urandom_range(0, 2)) ex[$urandom_range(0, 31)] ^= 1'b1;
            run(k, mode, ex, rt);
        end

        repeat (3) @(negedge clk);
        chk(q0.size() == 0 && q1.size() == 0, "sb_leftover", q0.size() + q1.size(), 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish before %0d cycles", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
